// File: rtl/alu_result_display.sv
// Converts the 4-bit {carry, sum} adder result to two BCD digits with a
// four-step double-dabble sequencer and drives two active-low 7-segment displays.
module alu_result_display #(
    parameter int unsigned BLANK_LEADING_ZERO = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] in_sum,
    input  logic       in_carry,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] hex1_n,
    output logic [6:0] hex0_n
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] HEX1_RST  = (BLANK_LEADING_ZERO != 0) ? SEG_BLANK : SEG_ZERO;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  sh_q, sh_d;
    logic [7:0]  bcd_q, bcd_d;
    logic        done_q, done_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [6:0]  hex1_q, hex1_d;
    logic [6:0]  hex0_q, hex0_d;

    logic [7:0]  bcd_adj;
    logic [11:0] step;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        tens_d  = tens_q;
        ones_d  = ones_q;
        hex1_d  = hex1_q;
        hex0_d  = hex0_q;

        // Add-3 correction precedes the shift so each nibble stays a valid digit.
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
        step = {bcd_adj[6:0], sh_q, 1'b0};

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = {in_carry, in_sum};
                    bcd_d   = 8'd0;
                    cnt_d   = 2'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = step[11:4];
                sh_d  = step[3:0];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    tens_d  = step[11:8];
                    ones_d  = step[7:4];
                    hex0_d  = seg7(step[7:4]);
                    hex1_d  = (step[11:8] == 4'd0 && BLANK_LEADING_ZERO != 0) ? SEG_BLANK
                                                                              : seg7(step[11:8]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            sh_q    <= 4'd0;
            bcd_q   <= 8'd0;
            done_q  <= 1'b0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            hex1_q  <= HEX1_RST;
            hex0_q  <= SEG_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            hex1_q  <= hex1_d;
            hex0_q  <= hex0_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign hex1_n   = hex1_q;
    assign hex0_n   = hex0_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Randomized and directed checks of alu_result_display against a decimal
// reference model, with blanking enabled (dut_a) and disabled (dut_b).
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] in_sum;
    logic       in_carry;

    logic       busy_a, done_a, busy_b, done_b;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;
    logic [6:0] hex1_a, hex0_a, hex1_b, hex0_b;

    int errors = 0;
    int checks = 0;
    int prev_v = 0;

    logic [6:0] seg_tbl [0:9];

    always #5 clk = ~clk;

    alu_result_display #(.BLANK_LEADING_ZERO(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_sum(in_sum), .in_carry(in_carry),
        .busy(busy_a), .done(done_a), .bcd_tens(tens_a), .bcd_ones(ones_a),
        .hex1_n(hex1_a), .hex0_n(hex0_a)
    );

    alu_result_display #(.BLANK_LEADING_ZERO(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_sum(in_sum), .in_carry(in_carry),
        .busy(busy_b), .done(done_b), .bcd_tens(tens_b), .bcd_ones(ones_b),
        .hex1_n(hex1_b), .hex0_n(hex0_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Display contents implied by an operand value: tens = v/10, ones = v%10.
    task automatic chk_out(input string tag, input int v);
        int t, o;
        t = v / 10;
        o = v % 10;
        chk({tag, " tens_a"}, {4'd0, tens_a}, 8'(t));
        chk({tag, " ones_a"}, {4'd0, ones_a}, 8'(o));
        chk({tag, " hex0_a"}, {1'b0, hex0_a}, {1'b0, seg_tbl[o]});
        chk({tag, " hex1_a"}, {1'b0, hex1_a}, (t == 0) ? 8'h7f : {1'b0, seg_tbl[t]});
        chk({tag, " tens_b"}, {4'd0, tens_b}, 8'(t));
        chk({tag, " ones_b"}, {4'd0, ones_b}, 8'(o));
        chk({tag, " hex0_b"}, {1'b0, hex0_b}, {1'b0, seg_tbl[o]});
        chk({tag, " hex1_b"}, {1'b0, hex1_b}, {1'b0, seg_tbl[t]});
    endtask

    task automatic chk_ctl(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, " busy_a"}, {7'd0, busy_a}, {7'd0, exp_busy});
        chk({tag, " done_a"}, {7'd0, done_a}, {7'd0, exp_done});
        chk({tag, " busy_b"}, {7'd0, busy_b}, {7'd0, exp_done ? 1'b0 : exp_busy});
        chk({tag, " done_b"}, {7'd0, done_b}, {7'd0, exp_done});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after a rising edge with the DUT idle. With hold=1
    // start stays high so the caller can chain back-to-back conversions.
    task automatic conv(input string tag, input int v, input bit hold);
        logic [3:0] vv;
        vv = 4'(v);
        start    = 1'b1;
        in_carry = vv[3];
        in_sum   = vv[2:0];
        tick();
        chk_ctl({tag, " accept"}, 1'b1, 1'b0);
        chk_out({tag, " accept"}, prev_v);
        for (int k = 1; k <= 4; k++) begin
            {in_carry, in_sum} = 4'($urandom_range(0, 15));
            start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            if (k < 4) begin
                chk_ctl($sformatf("%s step%0d", tag, k), 1'b1, 1'b0);
                chk_out($sformatf("%s step%0d", tag, k), prev_v);
            end
        end
        chk_ctl({tag, " done"}, 1'b0, 1'b1);
        chk_out({tag, " done"}, v);
        prev_v = v;
        if (!hold) begin
            start = 1'b0;
            tick();
            chk_ctl({tag, " idle"}, 1'b0, 1'b0);
            chk_out({tag, " idle"}, prev_v);
        end
    endtask

    initial begin
        seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
        seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
        seg_tbl[9] = 7'b0010000;

        rst = 1'b1; start = 1'b0; in_sum = 3'd0; in_carry = 1'b0;
        #2;
        chk_ctl("reset", 1'b0, 1'b0);
        chk_out("reset", 0);
        tick();
        rst = 1'b0;
        tick();

        conv("7+7", 14, 1'b0);
        conv("zero", 0, 1'b0);
        conv("nine", 9, 1'b0);
        conv("ten", 10, 1'b0);
        conv("fifteen", 15, 1'b0);
        for (int i = 0; i < 10; i++) conv($sformatf("rand%0d", i), int'($urandom_range(0, 15)), 1'b0);

        for (int i = 0; i < 4; i++) conv($sformatf("held%0d", i), int'($urandom_range(0, 15)), 1'b1);
        start = 1'b0;
        tick();
        chk_ctl("held idle", 1'b0, 1'b0);

        // Abort mid-conversion: outputs must drop to reset values without a clock.
        start = 1'b1; {in_carry, in_sum} = 4'd13;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        prev_v = 0;
        chk_ctl("abort", 1'b0, 1'b0);
        chk_out("abort", 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_ctl($sformatf("post-abort%0d", k), 1'b0, 1'b0);
        end
        conv("after-rst", 12, 1'b0);
        conv("after-rst2", 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_display.md
ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 The block SHALL expose parameter BLANK_LEADING_ZERO, default 1: 1 = blank the tens display when the tens digit is 0; 0 = show "0".
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to convert the current adder result.
REQ-005 The block SHALL have port in_sum, input, 3 bits: sum bits [2:0] from the 3-bit adder.
REQ-006 The block SHALL have port in_carry, input, 1 bit: carry out from the 3-bit adder.
REQ-007 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when new digits are valid.
REQ-009 The block SHALL have port bcd_tens, output, 4 bits: decimal tens digit of the result.
REQ-010 The block SHALL have port bcd_ones, output, 4 bits: decimal ones digit of the result.
REQ-011 The block SHALL have port hex1_n, output, 7 bits: tens display segments {g,f,e,d,c,b,a}, active low.
REQ-012 The block SHALL have port hex0_n, output, 7 bits: ones display segments {g,f,e,d,c,b,a}, active low.

Function
REQ-013 Operand SHALL be value = {in_carry, in_sum}, unsigned 4 bits, range 0..15, sampled only on the edge that accepts start.
REQ-014 The FSM SHALL have two states, IDLE and SHIFT, plus a 2-bit step counter.
REQ-015 IDLE with start=1 at an edge SHALL do all of: load value into the shift register, clear the 8-bit BCD accumulator, set cnt=0, enter SHIFT, set busy=1.
REQ-016 IDLE with start=0 SHALL hold all registers and outputs.
REQ-017 Each SHIFT edge SHALL perform one double-dabble step.
- First, add 3 to each BCD nibble that is >= 5.
- Then shift {BCD, shift register} left by 1.
- Then increment cnt.
REQ-018 The edge that performs the step with cnt==3 SHALL do all of: load bcd_tens/bcd_ones and both segment outputs from the final accumulator, drive done=1 and busy=0, return to IDLE.
REQ-019 Latency SHALL be fixed: start accepted at edge N -> done high for exactly the cycle after edge N+4. The earliest next start accepted is at edge N+5.
REQ-020 start SHALL be ignored while busy=1; in_sum and in_carry changes during SHIFT SHALL NOT affect the result.
REQ-021 done SHALL be high for exactly one cycle per accepted start and never otherwise.
REQ-022 bcd_tens, bcd_ones, hex1_n and hex0_n SHALL change only on the completing edge and otherwise hold their last value.
REQ-023 Segment encoding (active low, {g..a}) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 hex1_n SHALL be 1111111 (blank) when bcd_tens==0 and BLANK_LEADING_ZERO==1, and the encoding of bcd_tens otherwise.
REQ-025 bcd_tens SHALL only ever be 0 or 1, and bcd_ones 0..9; value 10 SHALL give tens=1, ones=0.

Reset
REQ-026 rst=1 SHALL immediately, without a clock, force all of:
- state=IDLE, cnt=0, busy=0, done=0;
- bcd_tens=0, bcd_ones=0;
- hex0_n=1000000;
- hex1_n=1111111 if BLANK_LEADING_ZERO==1, else 1000000.
REQ-027 rst asserted mid-conversion SHALL abort it with no done pulse and no change from reset values.
REQ-028 The first start accepted after rst deasserts SHALL convert normally with the REQ-019 latency.

Verification
REQ-029 in_sum=110, in_carry=1 (7+7), start pulse -> done 4 edges later; bcd_tens=1, bcd_ones=4, hex1_n=1111001, hex0_n=0011001.
REQ-030 in_sum=000, in_carry=0, start -> bcd 0/0, hex0_n=1000000; hex1_n=1111111 with BLANK_LEADING_ZERO=1, 1000000 with BLANK_LEADING_ZERO=0.
REQ-031 Boundaries: value 9 -> tens 0, ones 9, hex0_n=0010000; value 10 -> tens 1, ones 0; value 15 -> tens 1, ones 5.
REQ-032 start held high continuously with in_sum toggling during SHIFT -> one done every 5 cycles; each result equals the operand sampled at its accepting edge.
REQ-033 rst pulsed 2 cycles after start -> busy=0 immediately, no done pulse, all outputs at reset values; the next start completes correctly.
